ifft_frame_buffer: RTL and testbench

- Downstream of the IFFT loop core: captures its 16-bit output stream (o_valid/o_data) in frames of FRAME_LEN samples.
- Plays each complete frame out to the DAC/output path under a valid/ready handshake.
- Ping-pong dual-bank buffer: one bank fills while the other drains. Incoming frames are never split; a frame that cannot be stored is dropped whole and flagged.

---
 rtl/ifft_frame_buffer.sv | 165 ++++++++++++++++
 tb/tb_ifft_frame_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_frame_buffer.sv
// ifft_frame_buffer
//   Ping-pong frame buffer between the IFFT core output stream and the DAC path.
//   One bank fills from the IFFT while the other drains downstream. Frames are
//   stored and played back whole. A frame that arrives while both banks hold
//   undrained data is discarded as a unit and reported.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   i_valid, i_data     IFFT sample stream (no backpressure)
//   o_valid, o_ready    output handshake
//   o_data              output sample
//   o_sof, o_eof        first / last sample of a frame, qualified by o_valid
//   o_overflow          one-cycle pulse per dropped input frame
//   o_drop_cnt          saturating dropped-frame count
//
// Build option
//   IFFT_FB_OFFSET_BIN_EN  when defined, the output register holds offset binary
//                          (MSB inverted) for the DAC; otherwise two's complement.
//
// Read side: the IDLE / PREFETCH / STREAM sequence is carried by two valid bits.
// mem_vld marks the registered RAM read (prefetch / skid entry) and o_valid the
// output register. Both clear = IDLE, mem_vld only = PREFETCH, o_valid = STREAM.
// A read is issued whenever the skid entry is free or is moving to the output
// this cycle, giving one sample per cycle with o_ready held high and a
// bubble-free hop into the next frame when it is already full.
module ifft_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 8192,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_overflow,
  output logic [15:0]       o_drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic {FILL, DROP} wr_state_t;

  wr_state_t         wr_st;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;   // write address in FILL, sample count in DROP
  logic [1:0]        full;

  logic              rd_bank;   // bank of the sample in the output register
  logic              iss_bank;  // bank of the next RAM read
  logic [ADDR_W-1:0] iss_addr;
  logic              mem_vld, mem_sof, mem_eof;
  logic [DATA_W-1:0] mem_q;

  logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

  logic              wr_en, wr_last, drain_done, other_empty, out_load, iss;
  logic [DATA_W-1:0] out_d;

  assign wr_en      = (wr_st == FILL) && i_valid;
  assign wr_last    = i_valid && (wr_addr == LAST);
  assign drain_done = o_valid && o_ready && o_eof;
  // A drain finishing this cycle frees its bank for the writer immediately.
  assign other_empty = !full[!wr_bank] || (drain_done && (rd_bank != wr_bank));
  assign out_load   = mem_vld && (!o_valid || o_ready);
  assign iss        = full[iss_bank] && (!mem_vld || out_load);

`ifdef IFFT_FB_OFFSET_BIN_EN
  assign out_d = mem_q ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign out_d = mem_q;
`endif

  // Sample storage. Writer and reader never address the same bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= i_data;
    if (iss)   mem_q <= mem[{iss_bank, iss_addr}];
  end

  // Bank occupancy. Set and clear always target different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (drain_done)          full[rd_bank] <= 1'b0;
      if (wr_en && wr_last)    full[wr_bank] <= 1'b1;
    end
  end

  // Write FSM: advances in whole frames, whether storing or discarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st      <= FILL;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_overflow <= 1'b0;
      if (i_valid) begin
        if (wr_addr == LAST) begin
          wr_addr <= '0;
          if (wr_st == DROP) begin
            o_overflow <= 1'b1;
            if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
          end
          if (other_empty) begin
            wr_bank <= !wr_bank;
            wr_st   <= FILL;
          end else begin
            wr_st   <= DROP;
          end
        end else begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Read side: RAM prefetch/skid entry feeding the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank  <= 1'b0;
      iss_bank <= 1'b0;
      iss_addr <= '0;
      mem_vld  <= 1'b0;
      mem_sof  <= 1'b0;
      mem_eof  <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_sof    <= 1'b0;
      o_eof    <= 1'b0;
    end else begin
      if (iss) begin
        mem_vld <= 1'b1;
        mem_sof <= (iss_addr == '0);
        mem_eof <= (iss_addr == LAST);
        if (iss_addr == LAST) begin
          iss_addr <= '0;
          iss_bank <= !iss_bank;
        end else begin
          iss_addr <= iss_addr + ADDR_W'(1);
        end
      end else if (out_load) begin
        mem_vld <= 1'b0;
      end

      if (out_load) begin
        o_valid <= 1'b1;
        o_data  <= out_d;
        o_sof   <= mem_sof;
        o_eof   <= mem_eof;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      if (drain_done) rd_bank <= !rd_bank;
    end
  end

endmodule

// File: tb/tb_ifft_frame_buffer.sv
// Self-checking bench for ifft_frame_buffer. A 16-sample instance covers the
// handshake, overflow and reset scenarios; a default-size instance streams
// four full frames. Expected samples go into per-instance queues as they are
// driven and are popped as the DUT hands them off.
module tb_ifft_frame_buffer;

  localparam int FL  = 16;
  localparam int BFL = 8192;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_ready = 1'b1;
  logic        o_valid, o_sof, o_eof, o_overflow;
  logic [15:0] o_data, o_drop_cnt;

  logic        b_i_valid = 1'b0;
  logic [15:0] b_i_data = '0;
  logic        b_o_ready = 1'b1;
  logic        b_o_valid, b_o_sof, b_o_eof, b_o_overflow;
  logic [15:0] b_o_data, b_o_drop_cnt;

  ifft_frame_buffer #(.DATA_W(16), .FRAME_LEN(FL)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_sof(o_sof),
    .o_eof(o_eof), .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  ifft_frame_buffer u_big (
    .clk(clk), .rst_n(rst_n), .i_valid(b_i_valid), .i_data(b_i_data),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_sof(b_o_sof),
    .o_eof(b_o_eof), .o_overflow(b_o_overflow), .o_drop_cnt(b_o_drop_cnt)
  );

  exp_t exp_q[$];
  exp_t big_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ov_cnt = 0;
  int   big_ov = 0;
  bit   tog_en = 1'b0;

  function automatic logic [15:0] conv(input logic [15:0] d);
`ifdef IFFT_FB_OFFSET_BIN_EN
    return d ^ 16'h8000;
`else
    return d;
`endif
  endfunction

  // ---------------- monitors ----------------
  task automatic mon_small();
    exp_t e;
    bit hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic hold_s = 1'b0, hold_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
        continue;
      end
      if (o_overflow) ov_cnt++;
      if (hold_v) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== hold_d || o_sof !== hold_s || o_eof !== hold_e) begin
          failures++;
          $display("FAIL hold: got v=%b d=%h sof=%b eof=%b, required v=1 d=%h sof=%b eof=%b",
                   o_valid, o_data, o_sof, o_eof, hold_d, hold_s, hold_e);
        end
      end
      if (o_valid === 1'b1 && o_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got d=%h sof=%b eof=%b, required no output", o_data, o_sof, o_eof);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e.d || o_sof !== e.sof || o_eof !== e.eof) begin
            failures++;
            $display("FAIL sample: got d=%h sof=%b eof=%b, required d=%h sof=%b eof=%b",
                     o_data, o_sof, o_eof, e.d, e.sof, e.eof);
          end
        end
      end
      hold_v = (o_valid === 1'b1) && (o_ready === 1'b0);
      hold_d = o_data;
      hold_s = o_sof;
      hold_e = o_eof;
    end
  endtask

  task automatic mon_big();
    exp_t e;
    bit mid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mid = 1'b0;
        continue;
      end
      if (b_o_overflow) big_ov++;
      if (mid) begin
        checks++;
        if (b_o_valid !== 1'b1) begin
          failures++;
          $display("FAIL big_gap: got o_valid=%b inside a frame, required 1", b_o_valid);
        end
      end
      if (b_o_valid === 1'b1 && b_o_ready === 1'b1) begin
        checks++;
        if (big_q.size() == 0) begin
          failures++;
          $display("FAIL big_unexpected: got d=%h, required no output", b_o_data);
        end else begin
          e = big_q.pop_front();
          if (b_o_data !== e.d || b_o_sof !== e.sof || b_o_eof !== e.eof) begin
            failures++;
            $display("FAIL big_sample: got d=%h sof=%b eof=%b, required d=%h sof=%b eof=%b",
                     b_o_data, b_o_sof, b_o_eof, e.d, e.sof, e.eof);
          end
        end
      end
      mid = (b_o_valid === 1'b1) && (b_o_eof === 1'b0) && (b_o_ready === 1'b1);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_sample(input logic [15:0] d, input int k, input bit keep);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = d;
    if (keep) exp_q.push_back('{d: conv(d), sof: (k == 0), eof: (k == FL-1)});
  endtask

  task automatic drive_frame(input int base, input bit keep);
    for (int k = 0; k < FL; k++) drive_sample(16'(base + k), k, keep);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max);
    int c = 0;
    while (exp_q.size() != 0 && c < max) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d samples outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    i_valid = 1'b0;
    b_i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    big_q.delete();
    ov_cnt = 0;
    big_ov = 0;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {15'd0, o_valid}, 16'd0);
    chk("rst_sof", {15'd0, o_sof}, 16'd0);
    chk("rst_eof", {15'd0, o_eof}, 16'd0);
    chk("rst_overflow", {15'd0, o_overflow}, 16'd0);
    chk("rst_drop_cnt", o_drop_cnt, 16'd0);
    chk("rst_data", o_data, 16'd0);
    chk("rst_big_valid", {15'd0, b_o_valid}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    o_ready = 1'b1;
    drive_frame(0, 1'b1);
    @(posedge clk); #1;            // last sample written on this edge
    i_valid = 1'b0;
    chk("lat_w0", {15'd0, o_valid}, 16'd0);
    @(posedge clk); #1;
    chk("lat_w1", {15'd0, o_valid}, 16'd0);
    @(posedge clk); #1;
    chk("lat_w2_valid", {15'd0, o_valid}, 16'd1);
    chk("lat_w2_sof", {15'd0, o_sof}, 16'd1);
    wait_drain(64);
    idle(4);
    chk("single_ov", 16'(ov_cnt), 16'd0);
    chk("single_drop", o_drop_cnt, 16'd0);
  endtask

  task automatic test_ready_toggle();
    do_reset();
    tog_en = 1'b1;
    fork
      while (tog_en) begin
        @(posedge clk); #1;
        o_ready = !o_ready;
      end
    join_none
    drive_frame(0, 1'b1);
    drive_frame(16, 1'b1);
    drive_frame(32, 1'b0);          // both banks busy: this frame is discarded
    idle(1);
    wait_drain(200);
    tog_en = 1'b0;
    repeat (2) @(posedge clk);
    #2 o_ready = 1'b1;
    idle(4);
    chk("toggle_ov", 16'(ov_cnt), 16'd1);
    chk("toggle_drop", o_drop_cnt, 16'd1);
    chk("toggle_idle", {15'd0, o_valid}, 16'd0);
  endtask

  task automatic test_backpressure();
    do_reset();
    o_ready = 1'b0;
    for (int f = 0; f < 5; f++) drive_frame(f * FL, f < 2);
    idle(20);
    chk("bp_drop", o_drop_cnt, 16'd3);
    chk("bp_ov", 16'(ov_cnt), 16'd3);
    chk("bp_valid", {15'd0, o_valid}, 16'd1);
    chk("bp_sof", {15'd0, o_sof}, 16'd1);
    chk("bp_data", o_data, conv(16'd0));
    o_ready = 1'b1;
    wait_drain(100);
    idle(20);
    chk("bp_idle", {15'd0, o_valid}, 16'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    o_ready = 1'b1;
    drive_frame(0, 1'b1);
    for (int k = 0; k < 8; k++) drive_sample(16'(16 + k), k, 1'b0);
    @(posedge clk); #3;
    chk("mid_streaming", {15'd0, o_valid}, 16'd1);
    rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("mid_valid_drop", {15'd0, o_valid}, 16'd0);
    chk("mid_drop_cnt", o_drop_cnt, 16'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ov_cnt = 0;
    drive_frame(100, 1'b1);
    idle(1);
    wait_drain(64);
    idle(4);
    chk("mid_after_ov", 16'(ov_cnt), 16'd0);
    chk("mid_after_drop", o_drop_cnt, 16'd0);
  endtask

  task automatic test_offset_values();
    logic [15:0] d;
    do_reset();
    o_ready = 1'b1;
    for (int k = 0; k < FL; k++) begin
      case (k)
        0:       d = 16'h8000;
        1:       d = 16'h0000;
        2:       d = 16'h7FFF;
        default: d = 16'(k * 4099);
      endcase
      drive_sample(d, k, 1'b1);
    end
    idle(1);
    wait_drain(64);
`ifdef IFFT_FB_OFFSET_BIN_EN
    chk("conv_min", conv(16'h8000), 16'h0000);
    chk("conv_max", conv(16'h7FFF), 16'hFFFF);
`endif
  endtask

  task automatic test_default_frame();
    int c = 0;
    do_reset();
    b_o_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < BFL; k++) begin
        @(posedge clk); #1;
        b_i_valid = 1'b1;
        b_i_data  = 16'(k);
        big_q.push_back('{d: conv(16'(k)), sof: (k == 0), eof: (k == BFL-1)});
      end
      repeat (2) begin          // short input gap lets each drain finish in time
        @(posedge clk); #1;
        b_i_valid = 1'b0;
      end
    end
    while (big_q.size() != 0 && c < 20000) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (big_q.size() != 0) begin
      failures++;
      $display("FAIL big_drain: got %0d samples outstanding, required 0", big_q.size());
      big_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    chk("big_ov", 16'(big_ov), 16'd0);
    chk("big_drop", b_o_drop_cnt, 16'd0);
  endtask

  initial begin
    fork
      mon_small();
      mon_big();
    join_none
    test_reset();
    test_single_frame();
    test_ready_toggle();
    test_backpressure();
    test_reset_mid();
    test_offset_values();
    test_default_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
